// File: rtl/fp_mul_norm_round.sv
// Final stage of the single-precision multiplier: normalizes the 48-bit mantissa
// product, rounds to nearest-even, detects overflow/underflow and packs the result.
module fp_mul_norm_round #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int BIAS   = 127
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sign,
  input  logic [EXP_W+1:0]           in_exp_sum,
  input  logic [2*MANT_W-1:0]        in_prod,
  input  logic                       in_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MANT_W-1:0]    out_result,
  output logic                       out_overflow,
  output logic                       out_underflow
);

  localparam int PROD_W = 2 * MANT_W;
  localparam int FRAC_W = MANT_W - 1;
  localparam int SEXP_W = EXP_W + 3;
  localparam int RES_W  = 1 + EXP_W + FRAC_W;
  localparam logic signed [SEXP_W-1:0] BIAS_S  = SEXP_W'(BIAS);
  localparam logic signed [SEXP_W-1:0] EXP_MAX = SEXP_W'((1 << EXP_W) - 1);

  logic                     s1_valid;
  logic                     s1_ready;
  logic                     s2_ready;
  logic                     s1_sign;
  logic                     s1_zero;
  logic [FRAC_W-1:0]        s1_frac;
  logic                     s1_guard;
  logic                     s1_sticky;
  logic signed [SEXP_W-1:0] s1_exp;

  logic [FRAC_W-1:0]        norm_frac;
  logic                     norm_guard;
  logic                     norm_sticky;
  logic signed [SEXP_W-1:0] norm_exp;

  logic                     round_up;
  logic                     round_carry;
  logic [FRAC_W-1:0]        round_frac;
  logic signed [SEXP_W-1:0] round_exp;
  logic [RES_W-1:0]         next_result;
  logic                     next_overflow;
  logic                     next_underflow;

  assign s2_ready  = !out_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready;

  // A product of two 1.x significands lies in [1,4); bit 47 selects the extra shift.
  always_comb begin
    norm_exp = $signed({1'b0, in_exp_sum}) - BIAS_S;
    if (in_prod[PROD_W-1]) begin
      norm_frac   = in_prod[PROD_W-2 -: FRAC_W];
      norm_guard  = in_prod[MANT_W-1];
      norm_sticky = |in_prod[MANT_W-2:0];
      norm_exp    = norm_exp + SEXP_W'(1);
    end else begin
      norm_frac   = in_prod[PROD_W-3 -: FRAC_W];
      norm_guard  = in_prod[MANT_W-2];
      norm_sticky = |in_prod[MANT_W-3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && s1_ready) begin
      s1_sign   <= in_sign;
      s1_zero   <= in_zero;
      s1_frac   <= norm_frac;
      s1_guard  <= norm_guard;
      s1_sticky <= norm_sticky;
      s1_exp    <= norm_exp;
    end
  end

  // Round-carry wraps the fraction to zero, so only the exponent needs bumping.
  always_comb begin
    round_up                  = s1_guard && (s1_sticky || s1_frac[0]);
    {round_carry, round_frac} = {1'b0, s1_frac} + MANT_W'(round_up);
    round_exp                 = s1_exp + $signed({{(SEXP_W-1){1'b0}}, round_carry});
    next_result               = {s1_sign, EXP_W'(round_exp), round_frac};
    next_overflow             = 1'b0;
    next_underflow            = 1'b0;
    if (s1_zero) begin
      next_result = {s1_sign, {(RES_W-1){1'b0}}};
    end else if (round_exp >= EXP_MAX) begin
      next_result   = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      next_overflow = 1'b1;
    end else if (round_exp[SEXP_W-1] || (round_exp == '0)) begin
      next_result    = {s1_sign, {(RES_W-1){1'b0}}};
      next_underflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      if (s1_ready) s1_valid <= in_valid;
      if (s2_ready) out_valid <= s1_valid;
      if (s2_ready && s1_valid) begin
        out_result    <= next_result;
        out_overflow  <= next_overflow;
        out_underflow <= next_underflow;
      end
    end
  end

endmodule

// File: doc/fp_mul_norm_round.md
Name: fp_mul_norm_round

Overview:
- Downstream stage of the single-precision floating-point multiplier's 18-bit mantissa partial-sum adders.
- Consumes the completed 48-bit mantissa product, the raw exponent sum and the result sign.
- Normalizes, rounds to nearest-even, detects overflow/underflow and packs the IEEE-754 single-precision result.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- MANT_W, 24, significand width including hidden bit; product width is 2*MANT_W.
- EXP_W, 8, exponent field width.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- in_sign  input  1  result sign (sign_a XOR sign_b).
- in_exp_sum  input  EXP_W+2  biased exp_a + biased exp_b, unsigned.
- in_prod  input  2*MANT_W  mantissa product (1.x * 1.x).
- in_zero  input  1  either operand is zero.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  32  packed {sign, exp[7:0], frac[22:0]}.
- out_overflow  output  1  result saturated to infinity.
- out_underflow  output  1  result flushed to zero.

Behaviour:
- Reset: synchronous and active-high. Clears both stage valid bits. out_valid=0, out_result=0, out_overflow=0, out_underflow=0, in_ready=1 in the cycle after reset. Reset mid-operation discards all in-flight beats.
- Handshake: a beat transfers when valid&&ready, per side.
  - s2_ready = !s2_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready.
  - Full throughput of one beat per cycle when out_ready=1.
  - Latency: 2 cycles from input transfer to out_valid.
  - While out_valid&&!out_ready, out_result and the flags hold stable.
  - Simultaneous input accept and output drain in the same cycle is legal.
- Stage 1 (normalize), using a signed exponent of EXP_W+3 bits:
  - If prod[47]=1: frac=prod[46:24], guard=prod[23], sticky=|prod[22:0], exp=exp_sum-BIAS+1.
  - Else: frac=prod[45:23], guard=prod[22], sticky=|prod[21:0], exp=exp_sum-BIAS.
  - Register sign, zero, frac, guard, sticky and exp.
- Stage 2 (round and pack):
  - round_up = guard && (sticky || frac[0]).
  - {carry,frac} = frac + round_up. If carry=1: frac=0 and exp=exp+1.
  - Priority order:
    1. zero: result {sign,31'b0}, no flags.
    2. exp>=255: result {sign,8'hFF,23'b0}, overflow=1.
    3. exp<=0: result {sign,31'b0}, underflow=1. No denormals are produced.
    4. Otherwise: result {sign,exp[7:0],frac}.
- The flags are registered with out_result and are valid only while out_valid=1.
- NaN/Inf inputs are not handled in this block; they are resolved upstream.

Test Plan:
1. exp_sum=254, prod=48'h4000_0000_0000, sign=0 → out_result=32'h3F80_0000, no flags, out_valid exactly 2 cycles after accept.
2. exp_sum=254, prod=48'h9000_0000_0000 (1.5×1.5) → 32'h4010_0000. Back-to-back with test 1 at out_ready=1 gives one result per cycle.
3. Rounding, exp_sum=254:
   - prod=48'h4000_0040_0000 (tie, lsb 0) → 32'h3F80_0000.
   - prod=48'h4000_00C0_0000 (tie, lsb 1) → 32'h3F80_0002.
   - prod=48'h7FFF_FFC0_0000 (round carry-out) → 32'h4000_0000.
4. Overflow and underflow:
   - exp_sum=400, prod=48'h4000_0000_0000, sign=1 → 32'hFF80_0000, out_overflow=1.
   - exp_sum=100 → 32'h0000_0000, out_underflow=1.
   - in_zero=1, sign=1 → 32'h8000_0000, no flags.
5. Backpressure:
   - Hold out_ready=0 and drive 3 beats → only 2 accepted; in_ready=0 from the cycle after the 2nd accept; out_result stable.
   - Release out_ready → results emerge in order with none lost or duplicated.
6. Assert rst with 2 beats in flight → next cycle out_valid=0, in_ready=1, flags 0. A new beat after reset produces the correct result.
